// File: rtl/register_file_pkg.sv
// Shared constants for the pipeline register file: default widths and the
// hard-wired zero register.
package register_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
    localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

endpackage : register_file_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register masking plus the same-cycle
// write-through bypass from the writeback stage.
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              bypass_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    // bypass_en arrives already qualified with reset; a write to r0 never
    // reaches the bypass because the zero mask wins first.
    always_comb begin
        data = stored;
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end else if (bypass_en && (addr == wr_addr)) begin
            data = wr_data;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file: two bypassed read ports, one write port
// and an unbypassed debug read port.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_live;

    // Reset wins over a coincident write and also suppresses the bypass.
    assign wr_live = RegWrite && !rst && (WriteAddr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[WriteAddr] <= WriteData;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .addr      (ReadReg1),
        .stored    (regs[ReadReg1]),
        .bypass_en (wr_live),
        .wr_addr   (WriteAddr),
        .wr_data   (WriteData),
        .data      (ReadData1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .addr      (ReadReg2),
        .stored    (regs[ReadReg2]),
        .bypass_en (wr_live),
        .wr_addr   (WriteAddr),
        .wr_data   (WriteData),
        .data      (ReadData2)
    );

    assign DbgData = (DbgAddr == ADDR_W'(REG_ZERO)) ? '0 : regs[DbgAddr];

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, zero register, bypass,
// back-to-back writes, reset-vs-write and a full write/read sweep.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] DbgAddr;
    logic [DATA_W-1:0] DbgData;

    int errors = 0;
    int checks = 0;

    register_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWrite  (RegWrite),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .DbgAddr   (DbgAddr),
        .DbgData   (DbgData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] exp;

        rst       = 1'b1;
        RegWrite  = 1'b0;
        WriteAddr = '0;
        WriteData = '0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        DbgAddr   = '0;
        tick();
        tick();

        // Reset state.
        ReadReg1 = 5'd4; ReadReg2 = 5'd17; DbgAddr = 5'd31;
        #1;
        check("reset_rd1", ReadData1, 32'h0);
        check("reset_rd2", ReadData2, 32'h0);
        check("reset_dbg", DbgData, 32'h0);
        rst = 1'b0;

        // Write r5, then reset clears it.
        RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'hDEADBEEF;
        tick();
        RegWrite = 1'b0; DbgAddr = 5'd5;
        #1;
        check("r5_written", DbgData, 32'hDEADBEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0; ReadReg1 = 5'd5;
        #1;
        check("r5_reset_dbg", DbgData, 32'h0);
        check("r5_reset_rd1", ReadData1, 32'h0);

        // Zero register ignores writes and bypass.
        RegWrite = 1'b1; WriteAddr = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd0;
        #1;
        check("r0_bypass_rd1", ReadData1, 32'h0);
        tick();
        RegWrite = 1'b0; DbgAddr = 5'd0;
        #1;
        check("r0_dbg", DbgData, 32'h0);

        // Same-cycle bypass on both ports; debug stays unbypassed.
        RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'h12345678;
        ReadReg1 = 5'd9; ReadReg2 = 5'd9; DbgAddr = 5'd9;
        #1;
        check("byp_rd1", ReadData1, 32'h12345678);
        check("byp_rd2", ReadData2, 32'h12345678);
        check("byp_dbg_stored", DbgData, 32'h0);
        tick();
        RegWrite = 1'b0; WriteData = 'x;
        #1;
        check("after_byp_rd1", ReadData1, 32'h12345678);
        check("after_byp_rd2", ReadData2, 32'h12345678);
        check("x_data_idle_rd1", ReadData1, 32'h12345678);

        // Back-to-back writes to r3.
        RegWrite = 1'b1; WriteAddr = 5'd3; WriteData = 32'h1; ReadReg2 = 5'd3;
        #1;
        check("b2b_first_rd2", ReadData2, 32'h1);
        tick();
        WriteData = 32'h2;
        #1;
        check("b2b_second_rd2", ReadData2, 32'h2);
        tick();
        RegWrite = 1'b0; DbgAddr = 5'd3;
        #1;
        check("b2b_dbg", DbgData, 32'h2);

        // Ports resolve independently: port1 stored, port2 bypassed.
        RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'h55;
        ReadReg1 = 5'd3; ReadReg2 = 5'd9;
        #1;
        check("indep_rd1", ReadData1, 32'h2);
        check("indep_rd2", ReadData2, 32'h55);
        tick();

        // Reset coincident with a write: reset wins, no bypass while rst=1.
        rst = 1'b1; RegWrite = 1'b1; WriteAddr = 5'd7; WriteData = 32'hA5A5A5A5;
        ReadReg1 = 5'd7; ReadReg2 = 5'd3; DbgAddr = 5'd7;
        #1;
        check("rstw_pre_rd1", ReadData1, 32'h0);
        check("rstw_pre_rd2_stored", ReadData2, 32'h2);
        tick();
        #1;
        check("rstw_dbg7", DbgData, 32'h0);
        check("rstw_rd1", ReadData1, 32'h0);
        check("rstw_rd2_cleared", ReadData2, 32'h0);

        // Sweep: first write lands on the first edge with rst=0.
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            WriteAddr = ADDR_W'(i);
            WriteData = i * 32'h01010101;
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = ADDR_W'(i); ReadReg2 = ADDR_W'(i); DbgAddr = ADDR_W'(i);
            #1;
            exp = i * 32'h01010101;
            check($sformatf("sweep_rd1_r%0d", i), ReadData1, exp);
            check($sformatf("sweep_rd2_r%0d", i), ReadData2, exp);
            check($sformatf("sweep_dbg_r%0d", i), DbgData, exp);
        end

        // X data with RegWrite=0 leaves state untouched.
        RegWrite = 1'b0; WriteAddr = 5'd4; WriteData = 'x; DbgAddr = 5'd4; ReadReg1 = 5'd4;
        tick();
        check("x_idle_dbg4", DbgData, 32'h04040404);
        check("x_idle_rd1", ReadData1, 32'h04040404);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_file
